// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Releases NUM_CH reset channels in a staggered order after a common hold
//   period, then tracks time spent running and supervises a watchdog.
//
// Ports
//   clk          in   system clock, all state on rising edge
//   rst_n        in   asynchronous active-low reset
//   sw_rst_req   in   synchronous request to re-run the release sequence
//   wd_en        in   watchdog count enable
//   wd_kick      in   clears the watchdog counter
//   ch_rst       out  per-channel reset, active-high
//   seq_done     out  high once every channel has been released
//   timeout      out  sticky watchdog expiry flag
//   cycle_count  out  saturating count of cycles spent in RUN
module reset_sequencer #(
  parameter int NUM_CH         = 4,
  parameter int RESET_CYCLES   = 5,
  parameter int STAGGER_CYCLES = 2,
  parameter int TIMEOUT        = 100000,
  parameter int CNT_W          = 32,
  parameter int TIMEOUT_RESETS = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sw_rst_req,
  input  logic              wd_en,
  input  logic              wd_kick,
  output logic [NUM_CH-1:0] ch_rst,
  output logic              seq_done,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycle_count
);

  typedef enum logic [1:0] {SYNC, HOLD, STAGGER, RUN} state_t;

  // All channels drop together when there is nothing to stagger.
  localparam bit SIMUL = (NUM_CH == 1) || (STAGGER_CYCLES == 0);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_t state, state_next;

  logic              sync_ff;
  logic [31:0]       hold_cnt, hold_cnt_next;
  logic [31:0]       stag_cnt, stag_cnt_next;
  logic [5:0]        ch_idx, ch_idx_next;
  logic [CNT_W-1:0]  wd_cnt, wd_cnt_next;
  logic [NUM_CH-1:0] ch_rst_next;
  logic              seq_done_next;
  logic              timeout_next;
  logic [CNT_W-1:0]  cycle_count_next;
  logic [NUM_CH-1:0] release_mask;

  logic hold_done, stag_done, last_ch;
  logic sw_accept, wd_expire, to_restart, restart;

  // One-hot mask of the channel selected by ch_idx.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_mask
      assign release_mask[gi] = (ch_idx == 6'(gi));
    end
  endgenerate

  assign hold_done = (state == HOLD)    && (hold_cnt == 32'(RESET_CYCLES - 1));
  assign stag_done = (state == STAGGER) && (stag_cnt == 32'(STAGGER_CYCLES - 1));
  assign last_ch   = (ch_idx == 6'(NUM_CH - 1));
  assign sw_accept = sw_rst_req && (state != SYNC);

  // Expiry edge: the counter is about to reach TIMEOUT and no kick overrides it.
  assign wd_expire  = (state == RUN) && !timeout && wd_en && !wd_kick &&
                      (wd_cnt + CNT_W'(1) == TIMEOUT_C);
  assign to_restart = wd_expire && !sw_accept && (TIMEOUT_RESETS != 0);
  assign restart    = sw_accept || to_restart;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SYNC;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      SYNC:    if (sync_ff) state_next = HOLD;
      HOLD:    if (hold_done) state_next = SIMUL ? RUN : STAGGER;
      STAGGER: if (stag_done && last_ch) state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = SYNC;
    endcase
    if (restart) state_next = HOLD;
  end

  // Output / datapath next values
  always_comb begin
    ch_rst_next      = ch_rst;
    seq_done_next    = seq_done;
    cycle_count_next = cycle_count;
    hold_cnt_next    = hold_cnt;
    stag_cnt_next    = stag_cnt;
    ch_idx_next      = ch_idx;
    wd_cnt_next      = wd_cnt;
    timeout_next     = timeout;

    if (restart) begin
      ch_rst_next      = '1;
      seq_done_next    = 1'b0;
      cycle_count_next = '0;
      hold_cnt_next    = '0;
      stag_cnt_next    = '0;
      ch_idx_next      = '0;
    end else begin
      unique case (state)
        HOLD: begin
          if (hold_done) begin
            hold_cnt_next = '0;
            if (SIMUL) begin
              ch_rst_next   = '0;
              seq_done_next = 1'b1;
            end else begin
              ch_rst_next = ch_rst & ~release_mask;
              ch_idx_next = ch_idx + 6'd1;
            end
          end else begin
            hold_cnt_next = hold_cnt + 32'd1;
          end
        end
        STAGGER: begin
          if (stag_done) begin
            stag_cnt_next = '0;
            ch_rst_next   = ch_rst & ~release_mask;
            ch_idx_next   = ch_idx + 6'd1;
            if (last_ch) seq_done_next = 1'b1;
          end else begin
            stag_cnt_next = stag_cnt + 32'd1;
          end
        end
        RUN: begin
          if (cycle_count != {CNT_W{1'b1}})
            cycle_count_next = cycle_count + CNT_W'(1);
        end
        default: ;
      endcase
    end

    // Watchdog: a software restart clears everything; once expired it freezes.
    if (sw_accept) begin
      wd_cnt_next  = '0;
      timeout_next = 1'b0;
    end else if (!timeout) begin
      if (wd_kick) begin
        wd_cnt_next = '0;
      end else if ((state == RUN) && wd_en) begin
        wd_cnt_next = wd_cnt + CNT_W'(1);
        if (wd_expire) timeout_next = 1'b1;
      end
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_ff     <= 1'b0;
      ch_rst      <= '1;
      seq_done    <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
      hold_cnt    <= '0;
      stag_cnt    <= '0;
      ch_idx      <= '0;
      wd_cnt      <= '0;
    end else begin
      // First synchronizer stage; the SYNC->HOLD state transition acts as the second.
      sync_ff     <= 1'b1;
      ch_rst      <= ch_rst_next;
      seq_done    <= seq_done_next;
      timeout     <= timeout_next;
      cycle_count <= cycle_count_next;
      hold_cnt    <= hold_cnt_next;
      stag_cnt    <= stag_cnt_next;
      ch_idx      <= ch_idx_next;
      wd_cnt      <= wd_cnt_next;
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Testbench for reset_sequencer: two instances (staggered / timeout-only and
// simultaneous / timeout-restarts) driven by shared stimulus, checked against
// a time-since-sequence-start reference model through a scoreboard queue.
module tb_reset_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, sw_rst_req, wd_en, wd_kick;
  logic [3:0] ch_a, ch_b;
  logic       sd_a, sd_b, to_a, to_b;
  logic [7:0] cc_a, cc_b;

  reset_sequencer #(
    .NUM_CH(4), .RESET_CYCLES(5), .STAGGER_CYCLES(2),
    .TIMEOUT(10), .CNT_W(8), .TIMEOUT_RESETS(0)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .sw_rst_req(sw_rst_req), .wd_en(wd_en),
    .wd_kick(wd_kick), .ch_rst(ch_a), .seq_done(sd_a), .timeout(to_a),
    .cycle_count(cc_a)
  );

  reset_sequencer #(
    .NUM_CH(4), .RESET_CYCLES(5), .STAGGER_CYCLES(0),
    .TIMEOUT(10), .CNT_W(8), .TIMEOUT_RESETS(1)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .sw_rst_req(sw_rst_req), .wd_en(wd_en),
    .wd_kick(wd_kick), .ch_rst(ch_b), .seq_done(sd_b), .timeout(to_b),
    .cycle_count(cc_b)
  );

  // Reference model: edges since the sequence started, RUN cycles, watchdog.
  typedef struct {
    int sync_cnt;
    bit in_seq;
    int t;
    int run;
    int wd;
    bit to;
  } mdl_t;

  typedef struct {
    logic [3:0] ch_a; logic sd_a; logic to_a; logic [7:0] cc_a;
    logic [3:0] ch_b; logic sd_b; logic to_b; logic [7:0] cc_b;
  } exp_t;

  mdl_t m_a, m_b;
  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.sync_cnt = 0; m.in_seq = 0; m.t = 0; m.run = 0; m.wd = 0; m.to = 0;
    return m;
  endfunction

  function automatic mdl_t mdl_step(mdl_t m, bit sw, bit en, bit kick,
                                    int nch, int rc, int st, int tmo, bit tr);
    int last;
    bit was_run;
    last = rc + (nch - 1) * st;
    if (!m.in_seq) begin
      m.sync_cnt++;
      if (m.sync_cnt == 2) begin
        m.in_seq = 1;
        m.t = 0;
      end
      return m;
    end
    if (sw) begin
      m.t = 0; m.run = 0; m.wd = 0; m.to = 0;
      return m;
    end
    was_run = (m.t >= last);
    if (m.t < 1000000) m.t++;
    if (was_run && m.run < 255) m.run++;
    if (!m.to) begin
      if (kick) m.wd = 0;
      else if (was_run && en) begin
        m.wd++;
        if (m.wd == tmo) begin
          m.to = 1;
          if (tr) begin
            m.t = 0;
            m.run = 0;
          end
        end
      end
    end
    return m;
  endfunction

  function automatic logic [3:0] exp_ch(mdl_t m, int rc, int st);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = !(m.in_seq && (m.t >= rc + i * st));
    return r;
  endfunction

  function automatic logic exp_done(mdl_t m, int rc, int st);
    return m.in_seq && (m.t >= rc + 3 * st);
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
  endtask

  // One clock of stimulus: advance the model over the edge, apply new inputs,
  // optionally pulse rst_n low mid-cycle, then queue the expected outputs.
  task automatic cycle(input bit rstn, input bit pulse, input bit sw,
                       input bit en, input bit kick);
    exp_t e;
    @(posedge clk);
    if (!rst_n) begin
      m_a = mdl_reset();
      m_b = mdl_reset();
    end else begin
      m_a = mdl_step(m_a, sw_rst_req, wd_en, wd_kick, 4, 5, 2, 10, 0);
      m_b = mdl_step(m_b, sw_rst_req, wd_en, wd_kick, 4, 5, 0, 10, 1);
    end
    #1;
    rst_n = rstn; sw_rst_req = sw; wd_en = en; wd_kick = kick;
    if (!rstn) begin
      m_a = mdl_reset();
      m_b = mdl_reset();
    end
    if (pulse) begin
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      m_a = mdl_reset();
      m_b = mdl_reset();
    end
    e.ch_a = exp_ch(m_a, 5, 2); e.sd_a = exp_done(m_a, 5, 2);
    e.to_a = m_a.to;            e.cc_a = 8'(m_a.run);
    e.ch_b = exp_ch(m_b, 5, 0); e.sd_b = exp_done(m_b, 5, 0);
    e.to_b = m_b.to;            e.cc_b = 8'(m_b.run);
    exp_q.push_back(e);
  endtask

  // Monitor: compare every queued expectation on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        $display("t=%0t a: ch=%b done=%b to=%b cc=%0d | b: ch=%b done=%b to=%b cc=%0d",
                 $time, ch_a, sd_a, to_a, cc_a, ch_b, sd_b, to_b, cc_b);
        chk("a_ch_rst",      8'(ch_a), 8'(e.ch_a));
        chk("a_seq_done",    8'(sd_a), 8'(e.sd_a));
        chk("a_timeout",     8'(to_a), 8'(e.to_a));
        chk("a_cycle_count", cc_a,     e.cc_a);
        chk("b_ch_rst",      8'(ch_b), 8'(e.ch_b));
        chk("b_seq_done",    8'(sd_b), 8'(e.sd_b));
        chk("b_timeout",     8'(to_b), 8'(e.to_b));
        chk("b_cycle_count", cc_b,     e.cc_b);
      end
    end
  end

  initial begin
    rst_n = 1'b0; sw_rst_req = 1'b0; wd_en = 1'b0; wd_kick = 1'b0;
    m_a = mdl_reset();
    m_b = mdl_reset();

    repeat (3) cycle(0, 0, 0, 0, 0);              // held in reset
    repeat (9) cycle(1, 0, 0, 0, 0);              // release, partial sequence
    cycle(1, 1, 0, 0, 0);                         // async pulse mid-sequence
    repeat (300) cycle(1, 0, 0, 0, 0);            // full sequence + saturation
    repeat (40) cycle(1, 0, 0, 1, 0);             // un-kicked watchdog expiry
    cycle(1, 0, 1, 1, 0);                         // software restart
    for (int i = 0; i < 40; i++) cycle(1, 0, 0, 1, i == 22);
    repeat (5) cycle(1, 0, 1, 1, 0);              // held restart request
    repeat (30) cycle(1, 0, 0, 1, 0);
    for (int i = 0; i < 2000; i++)
      cycle($urandom_range(0, 299) != 0, $urandom_range(0, 299) == 0,
            $urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 11) == 0);

    @(negedge clk);
    #1;
    chk("queue_drained", 8'(exp_q.size()), 8'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
